// File: rtl/irq_controller.sv
// irq_controller: N-channel interrupt front-end for the FPGC CPU.
// Each line is synchronised, polarity-corrected and edge/level qualified
// into a pending latch. One prioritised request (lowest index wins) is
// presented to the CPU under a request/acknowledge handshake.
module irq_controller #(
  parameter int CHANNELS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_WIDTH    = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] irq_in,
  input  logic [CHANNELS-1:0] polarity,
  input  logic [CHANNELS-1:0] edge_mode,
  input  logic [CHANNELS-1:0] mask,
  input  logic [CHANNELS-1:0] clr,
  input  logic                ack,
  output logic                irq_out,
  output logic [ID_WIDTH-1:0] irq_id,
  output logic [CHANNELS-1:0] pending,
  output logic [CHANNELS-1:0] overflow
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [WARM_W-1:0] WARM_MAX = WARM_W'(SYNC_STAGES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  logic [CHANNELS-1:0] r_sync [0:SYNC_STAGES-1];
  logic [CHANNELS-1:0] r_prev_act;
  logic [WARM_W-1:0]   r_warm_cnt;
  logic                r_edge_arm;
  logic [CHANNELS-1:0] r_pending;
  logic [CHANNELS-1:0] r_overflow;
  state_t              r_state;
  logic [ID_WIDTH-1:0] r_irq_id;

  logic [CHANNELS-1:0] w_act;
  logic [CHANNELS-1:0] w_rise;
  logic                w_level_en;
  logic                w_edge_en;
  logic                w_ack_hit;
  logic [CHANNELS-1:0] w_set;
  logic [CHANNELS-1:0] w_clear;
  logic [CHANNELS-1:0] w_ovf_set;
  logic [CHANNELS-1:0] w_req;
  state_t              w_state_next;
  logic [ID_WIDTH-1:0] w_id_next;

  // Synchroniser chain: irq_in is asynchronous, so it crosses SYNC_STAGES flops.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of its neighbour; blocking '=' would collapse the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: this small register array is reset on purpose so the chain
      // restarts from a known value; large RAM-style arrays should not be.
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_act  = r_sync[SYNC_STAGES-1] ^ polarity;
  assign w_rise = w_act & ~r_prev_act;

  // Previous active level for edge detection; tracks act even under reset.
  always_ff @(posedge clk) begin
    r_prev_act <= w_act;
  end

  // Warm-up counter: saturates once the sync chain holds real line samples.
  // Edge events are armed one cycle later, because the first "rise" after
  // release is the chain filling from its reset value, not a line transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_warm_cnt <= '0;
      r_edge_arm <= 1'b0;
    end else begin
      if (r_warm_cnt != WARM_MAX) r_warm_cnt <= r_warm_cnt + 1'b1;
      r_edge_arm <= w_level_en;
    end
  end

  assign w_level_en = (r_warm_cnt == WARM_MAX);
  assign w_edge_en  = r_edge_arm;
  assign w_ack_hit  = (r_state == ST_REQ) && ack;

  // Per-channel set/clear/overflow terms; a set beats a clear in the same cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_set   = '0;
    w_clear = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_clear[i] = clr[i] | (w_ack_hit && (r_irq_id == ID_WIDTH'(i)));
      w_set[i]   = edge_mode[i] ? (w_edge_en & w_rise[i])
                                : (w_level_en & w_act[i]);
    end
    w_ovf_set = edge_mode & w_rise & r_pending & ~w_clear & {CHANNELS{w_edge_en}};
  end

  // Pending and overflow latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending  <= '0;
      r_overflow <= '0;
    end else begin
      r_pending  <= w_set | (r_pending & ~w_clear);
      r_overflow <= w_ovf_set | (r_overflow & ~w_clear);
    end
  end

  // Request FSM state register and latched channel ID.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_irq_id <= '0;
    end else begin
      r_state  <= w_state_next;
      r_irq_id <= w_id_next;
    end
  end

  // Next-state logic: pick the lowest unmasked pending channel in IDLE,
  // hold the request untouched in REQ until the CPU acknowledges.
  always_comb begin
    w_state_next = r_state;
    w_id_next    = r_irq_id;
    w_req        = r_pending & ~mask;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_state_next = ST_REQ;
          for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_req[i]) w_id_next = ID_WIDTH'(i);
          end
        end
      end
      ST_REQ: begin
        if (ack) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign irq_out  = (r_state == ST_REQ);
  assign irq_id   = r_irq_id;
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural model.
module tb_irq_controller;

  localparam int N  = 8;
  localparam int S  = 2;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  irq_in = '0;
  logic [N-1:0]  polarity = '0;
  logic [N-1:0]  edge_mode = '0;
  logic [N-1:0]  mask = '0;
  logic [N-1:0]  clr = '0;
  logic          ack = 1'b0;
  logic          irq_out;
  logic [IW-1:0] irq_id;
  logic [N-1:0]  pending;
  logic [N-1:0]  overflow;

  int n_checks = 0;
  int n_fail   = 0;

  irq_controller #(.CHANNELS(N), .SYNC_STAGES(S), .ID_WIDTH(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .polarity  (polarity),
    .edge_mode (edge_mode),
    .mask      (mask),
    .clr       (clr),
    .ack       (ack),
    .irq_out   (irq_out),
    .irq_id    (irq_id),
    .pending   (pending),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The line is seen S edges late (history of sampled irq_in); a level channel
  // is pending while active once S clean edges have passed since reset, an
  // edge channel needs one more edge so the chain-fill artefact is ignored.
  logic [N-1:0]  m_hist [S] = '{default: '0};
  logic [N-1:0]  m_act_prev = '0;
  logic [N-1:0]  m_pend = '0;
  logic [N-1:0]  m_ovf = '0;
  logic          m_busy = 1'b0;
  int            m_id = 0;
  int            m_since = 0;
  logic [N-1:0]  m_act, m_rise, m_set, m_clear, m_req, m_ovf_new;

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin
    m_act      = m_hist[S-1] ^ polarity;
    m_rise     = m_act & ~m_act_prev;
    m_act_prev = m_act;
    if (reset) begin
      m_pend = '0; m_ovf = '0; m_busy = 1'b0; m_id = 0; m_since = 0;
      for (int k = 0; k < S; k++) m_hist[k] = '0;
    end else begin
      m_clear = clr;
      if (m_busy && ack) m_clear[m_id] = 1'b1;
      for (int i = 0; i < N; i++)
        m_set[i] = edge_mode[i] ? (m_since >= S + 1 && m_rise[i]) : (m_since >= S && m_act[i]);
      m_ovf_new = (m_since >= S + 1) ? (edge_mode & m_rise & m_pend & ~m_clear) : '0;
      m_req  = m_pend & ~mask;
      m_pend = m_set | (m_pend & ~m_clear);
      m_ovf  = m_ovf_new | (m_ovf & ~m_clear);
      if (!m_busy) begin
        if (m_req != 0) begin m_busy = 1'b1; m_id = lowest(m_req); end
      end else if (ack) begin
        m_busy = 1'b0;
      end
      if (m_since < 1000) m_since++;
      for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = irq_in;
    end
  end

  // Compare process: every cycle, just after the active edge.
  always @(posedge clk) begin
    #1;
    check("model_irq_out",  {31'd0, irq_out}, {31'd0, m_busy});
    check("model_irq_id",   {29'd0, irq_id},  m_id);
    check("model_pending",  {24'd0, pending}, {24'd0, m_pend});
    check("model_overflow", {24'd0, overflow}, {24'd0, m_ovf});
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    cyc(n);
    reset = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  initial begin
    cyc(3);
    reset = 1'b0;
    check("reset_irq_out", {31'd0, irq_out}, 0);
    check("reset_pending", {24'd0, pending}, 0);

    // 1: ch2 edge, latency 3 to pending, 4 to irq_out, ack clears.
    edge_mode = 8'h04;
    cyc(5);
    irq_in[2] = 1'b1;
    cyc(2);
    check("t1_pend_early", {24'd0, pending}, 0);
    cyc(1);
    check("t1_pend", {24'd0, pending}, 32'h04);
    check("t1_out_early", {31'd0, irq_out}, 0);
    cyc(1);
    check("t1_out", {31'd0, irq_out}, 1);
    check("t1_id", {29'd0, irq_id}, 2);
    cyc(2);
    pulse_ack();
    check("t1_pend_acked", {24'd0, pending}, 0);
    check("t1_out_acked", {31'd0, irq_out}, 0);
    irq_in = '0;
    cyc(4);

    // 2: line held through reset; edge -> nothing, level -> pending at S+1.
    irq_in = 8'h20;
    edge_mode = 8'h20;
    do_reset(3);
    cyc(8);
    check("t2_edge_none", {24'd0, pending}, 0);
    edge_mode = 8'h00;
    do_reset(3);
    cyc(2);
    check("t2_lvl_early", {24'd0, pending}, 0);
    cyc(1);
    check("t2_lvl_pend", {24'd0, pending}, 32'h20);
    cyc(1);
    check("t2_lvl_id", {29'd0, irq_id}, 5);
    irq_in = '0;
    do_reset(3);

    // 3: ch1 and ch6 together -> 1 first, one idle cycle, then 6.
    edge_mode = 8'hFF;
    cyc(5);
    irq_in = 8'h42;
    cyc(3);
    check("t3_pend", {24'd0, pending}, 32'h42);
    cyc(1);
    check("t3_id1", {29'd0, irq_id}, 1);
    pulse_ack();
    check("t3_gap", {31'd0, irq_out}, 0);
    check("t3_pend6", {24'd0, pending}, 32'h40);
    cyc(1);
    check("t3_out6", {31'd0, irq_out}, 1);
    check("t3_id6", {29'd0, irq_id}, 6);
    pulse_ack();
    irq_in = '0;
    cyc(4);

    // 4: ch3 overflow, ack clears both, rise coincident with ack sets again.
    irq_in[3] = 1'b1;
    cyc(4);
    check("t4_id", {29'd0, irq_id}, 3);
    irq_in[3] = 1'b0;
    cyc(3);
    irq_in[3] = 1'b1;
    cyc(3);
    check("t4_ovf", {24'd0, overflow}, 32'h08);
    pulse_ack();
    check("t4_pend_clr", {24'd0, pending}, 0);
    check("t4_ovf_clr", {24'd0, overflow}, 0);
    irq_in[3] = 1'b0;
    cyc(4);
    irq_in[3] = 1'b1;
    cyc(4);
    irq_in[3] = 1'b0;
    cyc(4);
    irq_in[3] = 1'b1;
    cyc(2);
    pulse_ack();
    check("t4_set_wins", {24'd0, pending}, 32'h08);
    check("t4_no_ovf", {24'd0, overflow}, 0);
    cyc(1);
    check("t4_rereq", {31'd0, irq_out}, 1);
    pulse_ack();
    irq_in = '0;
    cyc(4);

    // 5: masked level ch4 latches but does not request; re-request after ack.
    edge_mode = 8'h00;
    mask = 8'h10;
    irq_in = 8'h10;
    cyc(5);
    check("t5_masked_pend", {24'd0, pending}, 32'h10);
    check("t5_masked_out", {31'd0, irq_out}, 0);
    mask = '0;
    cyc(1);
    check("t5_out", {31'd0, irq_out}, 1);
    check("t5_id", {29'd0, irq_id}, 4);
    pulse_ack();
    check("t5_gap", {31'd0, irq_out}, 0);
    check("t5_level_hold", {24'd0, pending}, 32'h10);
    cyc(1);
    check("t5_rereq", {31'd0, irq_out}, 1);
    irq_in = '0;
    cyc(3);
    pulse_ack();
    cyc(1);
    check("t5_done", {24'd0, pending}, 0);

    // 5b: clr during REQ drops pending, request holds until ack.
    edge_mode = 8'h80;
    irq_in = 8'h80;
    cyc(4);
    clr = 8'h80;
    cyc(1);
    clr = '0;
    check("t5b_clr_pend", {24'd0, pending}, 0);
    check("t5b_hold", {31'd0, irq_out}, 1);
    pulse_ack();
    check("t5b_ack", {31'd0, irq_out}, 0);
    irq_in = '0;
    cyc(4);

    // 6: ch0 active-low; reset in REQ returns everything to zero.
    edge_mode = 8'h01;
    polarity = 8'h01;
    irq_in = 8'h01;
    do_reset(3);
    cyc(6);
    check("t6_idle_high", {24'd0, pending}, 0);
    irq_in[0] = 1'b0;
    cyc(4);
    check("t6_out", {31'd0, irq_out}, 1);
    check("t6_id", {29'd0, irq_id}, 0);
    reset = 1'b1;
    cyc(1);
    check("t6_rst_out", {31'd0, irq_out}, 0);
    check("t6_rst_pend", {24'd0, pending}, 0);
    cyc(2);
    reset = 1'b0;
    cyc(5);

    // Randomized traffic, checked by the compare process every cycle.
    polarity  = N'($urandom);
    edge_mode = N'($urandom);
    for (int c = 0; c < 4000; c++) begin
      irq_in = irq_in ^ (N'($urandom) & N'($urandom) & N'($urandom));
      if ($urandom_range(0, 15) == 0) mask = N'($urandom);
      clr = ($urandom_range(0, 15) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      ack = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 199) == 0) polarity = N'($urandom);
      if ($urandom_range(0, 199) == 0) edge_mode = N'($urandom);
      cyc(1);
    end
    reset = 1'b0; ack = 1'b0; clr = '0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Parametrised interrupt front-end for the FPGC CPU.
- Replaces the fixed 8-input stabilizer plus the hard-wired int/ext_int lines with one N-channel block.
- Per channel: synchronisation, polarity select, edge/level mode, pending latch, mask and overflow flag.
- Presents one prioritised request with a channel ID to the CPU under a request/acknowledge handshake. Sits between external or asynchronous interrupt sources and the CPU interrupt input.

Parameters:
- CHANNELS, 8, number of interrupt inputs (1..16).
- SYNC_STAGES, 2, synchroniser flops per input (>=2).
- ID_WIDTH, 3, width of irq_id; 2^ID_WIDTH >= CHANNELS is required.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- irq_in  in  CHANNELS  raw interrupt lines, asynchronous to clk.
- polarity  in  CHANNELS  1 = line active-low, 0 = active-high.
- edge_mode  in  CHANNELS  1 = edge-triggered, 0 = level-triggered.
- mask  in  CHANNELS  1 = channel blocked from requesting.
- clr  in  CHANNELS  one-cycle software clear of pending/overflow.
- ack  in  1  CPU acknowledge of the current request.
- irq_out  out  1  request to CPU.
- irq_id  out  ID_WIDTH  channel index of the current request.
- pending  out  CHANNELS  pending latch state.
- overflow  out  CHANNELS  edge lost while already pending.

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high.
- Reset values:
  - irq_out=0, irq_id=0, pending=0, overflow=0.
  - Sync chains=0; FSM=IDLE; warm-up counter=0.
  - prev_act is loaded with act every cycle, including under reset.
- Synchroniser: each irq_in bit passes through SYNC_STAGES flops. act[i] = sync_out[i] XOR polarity[i].
- Edge detect: rise[i] = act[i] & ~prev_act[i]. prev_act is registered every cycle.
- Warm-up:
  - The counter counts 0..SYNC_STAGES after reset deasserts, then saturates.
  - Pending/overflow sets are suppressed until it saturates, so lines already active at reset generate no edge event.
  - Level-mode channels that are active become pending on the first cycle after warm-up.
- Pending set condition, once warm-up is done:
  - Edge mode: set on rise[i].
  - Level mode: set whenever act[i]=1.
- Pending clear: clr[i], or ack in REQ state with irq_id==i. On the same cycle as any set, set wins.
- Overflow: set when an edge-mode rise[i] occurs while pending[i]=1 and no clear is occurring that cycle. Cleared with pending by clr/ack; set wins.
- Mask affects requesting only. Masked channels still latch pending and overflow.
- FSM IDLE:
  - If (pending & ~mask) != 0, latch the lowest set index into irq_id and go to REQ.
  - irq_out=1 from the next cycle.
  - ack in IDLE is ignored.
- FSM REQ:
  - irq_out=1 and irq_id are held stable. The request is not withdrawn if mask or clr changes.
  - On ack: clear pending[irq_id] and overflow[irq_id], go to IDLE, irq_out=0 the next cycle.
  - Back-to-back requests therefore have at least one cycle of irq_out=0 between them.
  - If clr removes pending[irq_id] while in REQ, irq_out still holds until ack; the ack then has no further effect on pending.
- Latency: after warm-up, an irq_in transition reaches pending after SYNC_STAGES+1 clk edges and irq_out after SYNC_STAGES+2 edges (4 at default).
- Priority: fixed, lowest index highest. Evaluated only in IDLE; no preemption in REQ.
- Reset mid-REQ: everything returns to reset values next cycle and warm-up restarts.

Test Plan:
- Reset, warm-up elapsed, ch2 edge-mode active-high, irq_in[2] 0->1 at cycle 0 -> pending[2]=1 at cycle 3, irq_out=1 and irq_id=2 at cycle 4; ack at cycle 6 -> pending[2]=0, irq_out=0 at cycle 7.
- irq_in[5]=1 held through reset, edge mode -> no pending after warm-up. Same with level mode -> pending[5]=1 at cycle SYNC_STAGES+1 after reset release.
- ch1 and ch6 become pending the same cycle, mask=0 -> irq_id=1 first. After ack, one idle cycle, then irq_id=6.
- ch3 edge-mode pending, second rising edge before ack -> overflow[3]=1. ack -> pending[3]=0 and overflow[3]=0. A rise coincident with ack -> pending[3]=1 (set wins).
- ch4 pending with mask[4]=1 -> irq_out stays 0, pending[4]=1. Clear mask[4] -> irq_out=1, irq_id=4 next cycle. Level-mode ch4 still active at ack -> re-requests after one idle cycle.
- ch0 active-low (polarity=1), irq_in[0] idle high, then 1->0 -> request with irq_id=0. Assert reset while in REQ -> irq_out=0 and pending=0 the next cycle.
